// File: rtl/rv_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_alu_pkg
//  Brief    : Shared widths, PC increment and ALU opcode encoding for the
//             RV32I execute ALU / fetch PC unit.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_W_DEF = 12;
    localparam int PC_INC   = 4;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_PASSB = 5'd9,
        ALU_ADD4  = 5'd10,
        ALU_MUL   = 5'd11,
        ALU_MULH  = 5'd12
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Brief    : Combinational RV32I ALU with zero / less-than flags.
//             Define ALU_MUL_EN to add MUL / MULH (ops 11, 12).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_core
    import rv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [4:0]      alu_op,
    input  logic            alu_sign,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_neg
);

    logic [4:0]      w_shamt;
    logic            w_lt;
    logic [XLEN-1:0] w_result;

    assign w_shamt = alu_b[4:0];
    assign w_lt    = alu_sign ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);

`ifdef ALU_MUL_EN
    // Extending both operands to 2*XLEN makes one multiplier serve signed and unsigned
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;

    assign w_a_ext = {{XLEN{alu_sign & alu_a[XLEN-1]}}, alu_a};
    assign w_b_ext = {{XLEN{alu_sign & alu_b[XLEN-1]}}, alu_b};
    assign w_prod  = w_a_ext * w_b_ext;
`endif

    always_comb begin
        w_result = '0;
        case (alu_op_e'(alu_op))
            ALU_ADD:   w_result = alu_a + alu_b;
            ALU_SUB:   w_result = alu_a - alu_b;
            ALU_AND:   w_result = alu_a & alu_b;
            ALU_OR:    w_result = alu_a | alu_b;
            ALU_XOR:   w_result = alu_a ^ alu_b;
            ALU_SLL:   w_result = alu_a << w_shamt;
            ALU_SRL:   w_result = alu_a >> w_shamt;
            ALU_SRA:   w_result = XLEN'($signed(alu_a) >>> w_shamt);
            ALU_SLT:   w_result = {{(XLEN-1){1'b0}}, w_lt};
            ALU_PASSB: w_result = alu_b;
            ALU_ADD4:  w_result = alu_a + XLEN'(PC_INC);
`ifdef ALU_MUL_EN
            ALU_MUL:   w_result = w_prod[XLEN-1:0];
            ALU_MULH:  w_result = w_prod[2*XLEN-1:XLEN];
`endif
            default:   w_result = '0;
        endcase
    end

    assign alu_result = w_result;
    assign alu_zero   = (w_result == '0);
    assign alu_neg    = w_lt;

endmodule
`default_nettype wire

// File: rtl/rv_alu_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv_alu_pc_unit
//  Brief    : Fetch PC register with +4 incrementer and execute-stage ALU.
//             Define ALU_MUL_EN to enable the ALU multiplier ops.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_alu_pc_unit
    import rv_alu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int PC_RESET = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic [PC_W-1:0] pc_next,
    output logic [PC_W-1:0] pc_q,
    output logic [PC_W-1:0] pc_plus4,
    input  logic [4:0]      alu_op,
    input  logic            alu_sign,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_neg
);

    localparam logic [PC_W-1:0] c_pc_reset = PC_W'(PC_RESET);
    localparam logic [PC_W-1:0] c_pc_inc   = PC_W'(PC_INC);

    logic [PC_W-1:0] r_pc;

    // Reset wins over a pending load; pc_write low is a hazard stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= c_pc_reset;
        end else if (pc_write) begin
            r_pc <= pc_next;
        end
    end

    assign pc_q     = r_pc;
    assign pc_plus4 = r_pc + c_pc_inc;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .alu_op     (alu_op),
        .alu_sign   (alu_sign),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg)
    );

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_alu_pc_unit
//  Brief    : Directed self-checking bench for rv_alu_pc_unit (PC + ALU).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_alu_pc_unit;
    import rv_alu_pkg::*;

    localparam int K_PCQ  = 0;
    localparam int K_PCP4 = 1;
    localparam int K_RES  = 2;
    localparam int K_ZERO = 3;
    localparam int K_NEG  = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic [11:0] pc_next;
    logic [11:0] pc_q;
    logic [11:0] pc_plus4;
    logic [4:0]  alu_op;
    logic        alu_sign;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_neg;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    rv_alu_pc_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .pc_write   (pc_write),
        .pc_next    (pc_next),
        .pc_q       (pc_q),
        .pc_plus4   (pc_plus4),
        .alu_op     (alu_op),
        .alu_sign   (alu_sign),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_PCQ:   obs = {20'h0, pc_q};
                K_PCP4:  obs = {20'h0, pc_plus4};
                K_RES:   obs = alu_result;
                K_ZERO:  obs = {31'h0, alu_zero};
                default: obs = {31'h0, alu_neg};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_step(input string tag, input logic [4:0] op, input logic sign,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_zero,
                            input logic exp_neg);
        alu_op   = op;
        alu_sign = sign;
        alu_a    = a;
        alu_b    = b;
        push({tag, ".res"},  K_RES,  exp_res);
        push({tag, ".zero"}, K_ZERO, {31'h0, exp_zero});
        push({tag, ".neg"},  K_NEG,  {31'h0, exp_neg});
        #1;
        drain();
    endtask

    initial begin
        rst      = 1'b1;
        pc_write = 1'b1;
        pc_next  = 12'h123;
        alu_op   = 5'd0;
        alu_sign = 1'b0;
        alu_a    = 32'h0;
        alu_b    = 32'h0;

        // PC reset, release and load
        tick();
        tick();
        push("rst.pc_q", K_PCQ, 32'h0);
        push("rst.pc_plus4", K_PCP4, 32'h4);
        drain();
        rst = 1'b0;
        tick();
        push("load.pc_q", K_PCQ, 32'h123);
        push("load.pc_plus4", K_PCP4, 32'h127);
        drain();

        pc_write = 1'b0;
        pc_next  = 12'h040;
        for (int i = 0; i < 3; i++) begin
            tick();
            push("stall.pc_q", K_PCQ, 32'h123);
            drain();
        end
        pc_next  = 12'hFFC;
        pc_write = 1'b1;
        tick();
        push("wrap.pc_q", K_PCQ, 32'hFFC);
        push("wrap.pc_plus4", K_PCP4, 32'h000);
        drain();

        pc_write = 1'b0;
        rst      = 1'b1;
        tick();
        push("rst_stall.pc_q", K_PCQ, 32'h0);
        drain();
        rst = 1'b0;

        // ALU directed vectors
        alu_step("sub_eq",     ALU_SUB,   1'b1, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0);
        alu_step("sub_s",      ALU_SUB,   1'b1, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b1);
        alu_step("sub_u",      ALU_SUB,   1'b0, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b0);
        alu_step("slt_s",      ALU_SLT,   1'b1, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b1);
        alu_step("slt_u",      ALU_SLT,   1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
        alu_step("sra",        ALU_SRA,   1'b0, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0);
        alu_step("srl",        ALU_SRL,   1'b0, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0);
        alu_step("sll",        ALU_SLL,   1'b0, 32'h1,        32'hFFFFFFE3, 32'h8,        1'b0, 1'b1);
        alu_step("and",        ALU_AND,   1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        alu_step("or",         ALU_OR,    1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
        alu_step("xor",        ALU_XOR,   1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0);
        alu_step("add_ovf",    ALU_ADD,   1'b1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0);
        alu_step("add_wrap",   ALU_ADD,   1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
        alu_step("passb",      ALU_PASSB, 1'b0, 32'h0,        32'hABCDE000, 32'hABCDE000, 1'b0, 1'b1);
        alu_step("add4",       ALU_ADD4,  1'b0, 32'h100,      32'h0,        32'h104,      1'b0, 1'b0);
        alu_step("op20",       5'd20,     1'b0, 32'h3,        32'h7,        32'h0,        1'b1, 1'b1);
`ifdef ALU_MUL_EN
        alu_step("mul",        ALU_MUL,   1'b1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 1'b1);
        alu_step("mulh_s",     ALU_MULH,  1'b1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1'b0, 1'b1);
        alu_step("mulh_u",     ALU_MULH,  1'b0, 32'hFFFFFFFF, 32'h2,        32'h00000001, 1'b0, 1'b0);
`else
        alu_step("mul_off",    ALU_MUL,   1'b1, 32'hFFFFFFFF, 32'h2,        32'h0,        1'b1, 1'b1);
        alu_step("mulh_off",   ALU_MULH,  1'b0, 32'hFFFFFFFF, 32'h2,        32'h0,        1'b1, 1'b0);
`endif

        // ALU must ignore reset and PC must keep its value while stalled
        rst = 1'b1;
        tick();
        alu_step("alu_in_rst", ALU_ADD,   1'b0, 32'h10,       32'h20,       32'h30,       1'b0, 1'b1);
        push("rst2.pc_q", K_PCQ, 32'h0);
        drain();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
